// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
// Optional IMEM_WAIT_EN: FETCH stalls on imem_ready before loading IR.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        breq,
  input  logic        brlt,
`ifdef IMEM_WAIT_EN
  input  logic        imem_ready,
`endif
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pcsel,
  output logic        regwen,
  output logic [2:0]  immsel,
  output logic        asel,
  output logic        bsel,
  output logic        brun,
  output logic [2:0]  alusel,
  output logic        mem_req,
  output logic        memrw,
  output logic [1:0]  wbsel,
  output logic        halt,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  state_e      state_q;
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic       is_r, is_i, is_ld, is_st;
  logic       is_br, is_jal, is_jalr, is_auipc;
  logic       alu_f3_ok;
  logic       legal;
  logic       taken;
  logic       retire;
  logic [2:0] imm_t;
  logic [2:0] alu_op;
  logic       unused_ins;

  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign alt = ins[30];
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_auipc = (opc == 7'b0010111);

  assign alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b111) ||
                     (f3 == 3'b110) || (f3 == 3'b100);

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_r:  legal = alu_f3_ok && (!alt || f3 == 3'b000);
      is_i:  legal = alu_f3_ok && !alt;
      is_br: legal = (f3[2:1] != 2'b01);
      is_ld, is_st, is_jal, is_jalr, is_auipc:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_t = 3'b000;
    unique case (1'b1)
      is_i, is_ld, is_jalr: imm_t = 3'b001;
      is_st:                imm_t = 3'b010;
      is_br:                imm_t = 3'b011;
      is_jal:               imm_t = 3'b100;
      is_auipc:             imm_t = 3'b101;
      default:              imm_t = 3'b000;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (is_r || is_i) begin
      case (f3)
        3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_op = ALU_AND;
        3'b110:  alu_op = ALU_OR;
        3'b100:  alu_op = ALU_XOR;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  // Unsigned/signed choice lives in brun; both share brlt here.
  always_comb begin
    case (f3)
      3'b000:         taken = breq;
      3'b001:         taken = !breq;
      3'b100, 3'b110: taken = brlt;
      3'b101, 3'b111: taken = !brlt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    ir_load = 1'b0;
    pc_load = 1'b0;
    pcsel   = 1'b0;
    regwen  = 1'b0;
    immsel  = 3'b000;
    asel    = 1'b0;
    bsel    = 1'b0;
    brun    = 1'b0;
    alusel  = ALU_ADD;
    mem_req = 1'b0;
    memrw   = 1'b0;
    wbsel   = 2'd0;
    halt    = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
`ifdef IMEM_WAIT_EN
          ir_load = imem_ready;
`else
          ir_load = 1'b1;
`endif
        end
        DECODE: immsel = legal ? imm_t : 3'b000;
        EXEC: begin
          immsel = imm_t;
          alusel = alu_op;
          asel   = is_br || is_jal || is_auipc;
          bsel   = !is_r;
          if (is_br) begin
            pc_load = 1'b1;
            pcsel   = taken;
            brun    = f3[2] & f3[1];
          end
        end
        MEM: begin
          immsel  = imm_t;
          mem_req = 1'b1;
          memrw   = is_st;
          pc_load = is_st && mem_ready;
        end
        WB: begin
          immsel  = imm_t;
          regwen  = 1'b1;
          pc_load = 1'b1;
          pcsel   = is_jal || is_jalr;
          if (is_ld)
            wbsel = 2'd1;
          else if (is_jal || is_jalr)
            wbsel = 2'd2;
          else
            wbsel = 2'd0;
        end
        HALT:    halt = 1'b1;
        default: halt = 1'b0;
      endcase
    end
  end

  assign retire = (state_q == EXEC && is_br) ||
                  (state_q == MEM && is_st && mem_ready) ||
                  (state_q == WB);

  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
      case (state_q)
        FETCH: begin
`ifdef IMEM_WAIT_EN
          if (imem_ready) state_q <= DECODE;
`else
          state_q <= DECODE;
`endif
        end
        DECODE: state_q <= legal ? EXEC : HALT;
        EXEC: begin
          if (is_ld || is_st)
            state_q <= MEM;
          else if (is_br)
            state_q <= FETCH;
          else
            state_q <= WB;
        end
        MEM: begin
          if (mem_ready)
            state_q <= is_st ? FETCH : WB;
        end
        WB:      state_q <= FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = 32'h0;
  logic        breq = 1'b0;
  logic        brlt = 1'b0;
  logic        mem_ready = 1'b0;
`ifdef IMEM_WAIT_EN
  logic        imem_ready = 1'b1;
  localparam int FW = 2;
`else
  localparam int FW = 0;
`endif
  logic        ir_load, pc_load, pcsel, regwen;
  logic [2:0]  immsel, alusel, state;
  logic        asel, bsel, brun, mem_req, memrw, halt;
  logic [1:0]  wbsel;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .ins(ins),
    .breq(breq), .brlt(brlt),
`ifdef IMEM_WAIT_EN
    .imem_ready(imem_ready),
`endif
    .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_load(pc_load),
    .pcsel(pcsel), .regwen(regwen),
    .immsel(immsel), .asel(asel), .bsel(bsel),
    .brun(brun), .alusel(alusel),
    .mem_req(mem_req), .memrw(memrw),
    .wbsel(wbsel), .halt(halt),
    .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        irl, pcl, pcs, rgw;
    logic [2:0]  imm;
    logic        asl, bsl, bru;
    logic [2:0]  alu;
    logic        mrq, mrw;
    logic [1:0]  wb;
    logic        hlt;
    logic [31:0] ir;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;
  int    icnt = 0;
  exp_t  me, ma;
  string mn;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      mn = nq.pop_front();
      ma = {state, ir_load, pc_load, pcsel, regwen, immsel,
            asel, bsel, brun, alusel, mem_req, memrw,
            wbsel, halt, instret};
      checks++;
      if (ma !== me) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", mn, ma, me);
      end
    end
  end

  function automatic exp_t z(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.ir = icnt;
    return e;
  endfunction

  task automatic cyc(input exp_t e, input string n);
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] i, input int w);
    exp_t e;
    ins = i;
    for (int k = 0; k < w; k++) begin
`ifdef IMEM_WAIT_EN
      imem_ready = 1'b0;
`endif
      cyc(z(3'd0), "fetch wait");
    end
`ifdef IMEM_WAIT_EN
    imem_ready = 1'b1;
`endif
    e = z(3'd0);
    e.irl = 1'b1;
    cyc(e, "fetch");
  endtask

  task automatic alu_seq(input string n, input int w,
                         input logic [31:0] i, input logic [2:0] imm,
                         input logic asl, input logic bsl,
                         input logic [2:0] alu, input logic pcs,
                         input logic [1:0] wb);
    exp_t e;
    fetch(i, w);
    e = z(3'd1); e.imm = imm;
    cyc(e, {n, " dec"});
    e = z(3'd2); e.imm = imm; e.asl = asl; e.bsl = bsl; e.alu = alu;
    cyc(e, {n, " exe"});
    e = z(3'd4); e.imm = imm; e.rgw = 1'b1; e.pcl = 1'b1;
    e.pcs = pcs; e.wb = wb;
    cyc(e, {n, " wb"});
    icnt++;
  endtask

  task automatic br_seq(input string n, input logic [31:0] i,
                        input logic bq, input logic bl,
                        input logic tk, input logic bu);
    exp_t e;
    fetch(i, 0);
    breq = bq;
    brlt = bl;
    e = z(3'd1); e.imm = 3'b011;
    cyc(e, {n, " dec"});
    e = z(3'd2); e.imm = 3'b011; e.asl = 1'b1; e.bsl = 1'b1;
    e.pcl = 1'b1; e.pcs = tk; e.bru = bu;
    cyc(e, {n, " exe"});
    icnt++;
    breq = 1'b0;
    brlt = 1'b0;
  endtask

  task automatic ld_seq(input logic [31:0] i, input int waits);
    exp_t e;
    fetch(i, 0);
    e = z(3'd1); e.imm = 3'b001;
    cyc(e, "lw dec");
    e = z(3'd2); e.imm = 3'b001; e.bsl = 1'b1;
    cyc(e, "lw exe");
    e = z(3'd3); e.imm = 3'b001; e.mrq = 1'b1;
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      cyc(e, "lw mem wait");
    end
    mem_ready = 1'b1;
    cyc(e, "lw mem ack");
    mem_ready = 1'b0;
    e = z(3'd4); e.imm = 3'b001; e.rgw = 1'b1; e.pcl = 1'b1; e.wb = 2'd1;
    cyc(e, "lw wb");
    icnt++;
  endtask

  task automatic st_front(input logic [31:0] i);
    exp_t e;
    fetch(i, 0);
    e = z(3'd1); e.imm = 3'b010;
    cyc(e, "sw dec");
    e = z(3'd2); e.imm = 3'b010; e.bsl = 1'b1;
    cyc(e, "sw exe");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(z(3'd0), "reset");
    rst = 1'b0;

    alu_seq("add", FW, 32'h002081B3, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0);
    br_seq("beq t", 32'h00208463, 1'b1, 1'b0, 1'b1, 1'b0);
    br_seq("beq nt", 32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0);
    br_seq("bltu t", 32'h0020E463, 1'b0, 1'b1, 1'b1, 1'b1);
    ld_seq(32'h0000A183, 3);

    st_front(32'h0030A223);
    mem_ready = 1'b1;
    e = z(3'd3); e.imm = 3'b010; e.mrq = 1'b1; e.mrw = 1'b1; e.pcl = 1'b1;
    cyc(e, "sw mem ack");
    mem_ready = 1'b0;
    icnt++;

    alu_seq("jal", 0, 32'h008000EF, 3'b100, 1'b1, 1'b1, 3'b000, 1'b1, 2'd2);
    alu_seq("xori", 0, 32'h0FF0C093, 3'b001, 1'b0, 1'b1, 3'b100, 1'b0, 2'd0);
    alu_seq("sub", 0, 32'h402081B3, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 2'd0);
    alu_seq("andi", 0, 32'h0FF0F093, 3'b001, 1'b0, 1'b1, 3'b010, 1'b0, 2'd0);

    st_front(32'h0030A223);
    e = z(3'd3); e.imm = 3'b010; e.mrq = 1'b1; e.mrw = 1'b1;
    cyc(e, "sw mem wait");
    rst = 1'b1;
    mem_ready = 1'b1;
    cyc(z(3'd3), "rst in mem");
    rst = 1'b0;
    mem_ready = 1'b0;
    icnt = 0;

    fetch(32'h000010B7, 0);
    cyc(z(3'd1), "lui dec");
    e = z(3'd7); e.hlt = 1'b1;
    for (int k = 0; k < 10; k++) cyc(e, "halt hold");
    rst = 1'b1;
    cyc(z(3'd7), "rst in halt");
    rst = 1'b0;

    fetch(32'h00109093, 0);
    cyc(z(3'd1), "slli dec");
    cyc(e, "slli halt");
    rst = 1'b1;
    cyc(z(3'd7), "rst final");

    #10;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
